// File: rtl/siw_memory_bram_reader.sv
// Streaming read initiator for one BRAM port: walks a base/stride/count pattern, issues credit-limited reads
// and buffers returns in a small FIFO. Build option SIW_MEMORY_BRAM_READER_STRIDE_EN adds a stride port (default step 1).
module siw_memory_bram_reader (
  input  logic        siw_memory_bram_reader_clk,
  input  logic        siw_memory_bram_reader_reset,
  input  logic        siw_memory_bram_reader_start,
  input  logic        siw_memory_bram_reader_abort,
  input  logic [9:0]  siw_memory_bram_reader_base_addr,
`ifdef SIW_MEMORY_BRAM_READER_STRIDE_EN
  input  logic [9:0]  siw_memory_bram_reader_stride,
`endif
  input  logic [10:0] siw_memory_bram_reader_count,
  output logic        siw_memory_bram_reader_busy,
  output logic        siw_memory_bram_reader_done,
  output logic        siw_memory_bram_reader_mem_enable,
  output logic        siw_memory_bram_reader_mem_write_en,
  output logic [9:0]  siw_memory_bram_reader_mem_address,
  output logic [31:0] siw_memory_bram_reader_mem_input_data,
  output logic [1:0]  siw_memory_bram_reader_mem_conf,
  input  logic [31:0] siw_memory_bram_reader_mem_output_data,
  output logic [31:0] siw_memory_bram_reader_out_data,
  output logic        siw_memory_bram_reader_out_valid,
  input  logic        siw_memory_bram_reader_out_ready
);

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam logic [3:0] CREDIT_LIMIT = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] step;
  logic [10:0]       remaining_q;
  logic [1:0]        vld_q;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W:0]    fifo_count_q;
  logic              done_zero_q;

  logic [1:0] inflight;
  logic [3:0] committed;
  logic       credit_ok;
  logic       issue;
  logic       push;
  logic       pop;
  logic       drain_done;
  logic       start_ok;
  logic       count_zero;

  // Credit covers words already buffered plus reads still in the memory pipeline,
  // so a returning word always has a FIFO slot waiting for it.
  assign inflight   = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};
  assign committed  = {1'b0, fifo_count_q} + {2'b00, inflight};
  assign credit_ok  = committed < CREDIT_LIMIT;
  assign issue      = (state_q == ISSUE) && credit_ok && !siw_memory_bram_reader_abort;
  assign push       = vld_q[1];
  assign pop        = siw_memory_bram_reader_out_valid && siw_memory_bram_reader_out_ready;
  assign drain_done = (state_q == DRAIN) && (vld_q == 2'b00) && (fifo_count_q == '0);
  assign count_zero = (siw_memory_bram_reader_count == 11'd0);
  assign start_ok   = (state_q == IDLE) && siw_memory_bram_reader_start && !siw_memory_bram_reader_abort;

`ifdef SIW_MEMORY_BRAM_READER_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge siw_memory_bram_reader_clk or posedge siw_memory_bram_reader_reset) begin
    if (siw_memory_bram_reader_reset) begin
      stride_q <= '0;
    end else if (start_ok && !count_zero) begin
      stride_q <= siw_memory_bram_reader_stride;
    end
  end

  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  always_ff @(posedge siw_memory_bram_reader_clk or posedge siw_memory_bram_reader_reset) begin
    if (siw_memory_bram_reader_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (siw_memory_bram_reader_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (siw_memory_bram_reader_start && !count_zero) state_d = ISSUE;
        ISSUE:   if (issue && remaining_q == 11'd1) state_d = DRAIN;
        DRAIN:   if (drain_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    siw_memory_bram_reader_busy       = (state_q != IDLE);
    siw_memory_bram_reader_done       = (done_zero_q | drain_done) & ~siw_memory_bram_reader_abort;
    siw_memory_bram_reader_mem_enable = issue;
  end

  // Address walk; the 10-bit add wraps modulo the memory depth.
  always_ff @(posedge siw_memory_bram_reader_clk or posedge siw_memory_bram_reader_reset) begin
    if (siw_memory_bram_reader_reset) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      done_zero_q <= 1'b0;
    end else begin
      done_zero_q <= start_ok && count_zero;
      if (start_ok && !count_zero) begin
        cur_addr_q  <= siw_memory_bram_reader_base_addr;
        remaining_q <= siw_memory_bram_reader_count;
      end else if (issue) begin
        cur_addr_q  <= cur_addr_q + step;
        remaining_q <= remaining_q - 11'd1;
      end
    end
  end

  // Valid pipe mirrors the fixed two-cycle BRAM latency.
  always_ff @(posedge siw_memory_bram_reader_clk or posedge siw_memory_bram_reader_reset) begin
    if (siw_memory_bram_reader_reset) begin
      vld_q <= 2'b00;
    end else if (siw_memory_bram_reader_abort) begin
      vld_q <= 2'b00;
    end else begin
      vld_q <= {vld_q[0], issue};
    end
  end

  always_ff @(posedge siw_memory_bram_reader_clk or posedge siw_memory_bram_reader_reset) begin
    if (siw_memory_bram_reader_reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fifo_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (siw_memory_bram_reader_abort) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= siw_memory_bram_reader_mem_output_data;
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + (PTR_W+1)'(1);
        2'b01:   fifo_count_q <= fifo_count_q - (PTR_W+1)'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  assign siw_memory_bram_reader_out_valid      = (fifo_count_q != '0);
  assign siw_memory_bram_reader_out_data       = fifo_mem[rd_ptr_q];
  assign siw_memory_bram_reader_mem_address    = cur_addr_q;
  assign siw_memory_bram_reader_mem_write_en   = 1'b0;
  assign siw_memory_bram_reader_mem_input_data = '0;
  assign siw_memory_bram_reader_mem_conf       = 2'd0;

endmodule

// File: tb/tb_siw_memory_bram_reader.sv
// Bench for siw_memory_bram_reader: a 2-cycle BRAM model feeds the DUT, and a scoreboard built from the
// base + i*stride mod 1024 rule checks issued addresses, streamed words, credit, busy and done timing.
module tb_siw_memory_bram_reader;

`ifdef SIW_MEMORY_BRAM_READER_STRIDE_EN
  localparam bit STRIDE_EN_TB = 1'b1;
`else
  localparam bit STRIDE_EN_TB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [9:0]  base_addr;
  logic [9:0]  stride_drv;
  logic [10:0] count;
  logic        busy;
  logic        done;
  logic        mem_enable;
  logic        mem_write_en;
  logic [9:0]  mem_address;
  logic [31:0] mem_input_data;
  logic [1:0]  mem_conf;
  logic [31:0] mem_output_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  siw_memory_bram_reader dut (
    .siw_memory_bram_reader_clk            (clk),
    .siw_memory_bram_reader_reset          (reset),
    .siw_memory_bram_reader_start          (start),
    .siw_memory_bram_reader_abort          (abort),
    .siw_memory_bram_reader_base_addr      (base_addr),
`ifdef SIW_MEMORY_BRAM_READER_STRIDE_EN
    .siw_memory_bram_reader_stride         (stride_drv),
`endif
    .siw_memory_bram_reader_count          (count),
    .siw_memory_bram_reader_busy           (busy),
    .siw_memory_bram_reader_done           (done),
    .siw_memory_bram_reader_mem_enable     (mem_enable),
    .siw_memory_bram_reader_mem_write_en   (mem_write_en),
    .siw_memory_bram_reader_mem_address    (mem_address),
    .siw_memory_bram_reader_mem_input_data (mem_input_data),
    .siw_memory_bram_reader_mem_conf       (mem_conf),
    .siw_memory_bram_reader_mem_output_data(mem_output_data),
    .siw_memory_bram_reader_out_data       (out_data),
    .siw_memory_bram_reader_out_valid      (out_valid),
    .siw_memory_bram_reader_out_ready      (out_ready)
  );

  // BRAM model: enable in cycle N returns data during N+2; garbage when not enabled.
  logic [31:0] mem_model [1024];
  logic [31:0] bram_d1;

  always @(posedge clk) begin
    bram_d1         <= mem_enable ? mem_model[mem_address] : 32'hDEAD_BEEF;
    mem_output_data <= bram_d1;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [9:0]  exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  int  outstanding     = 0;
  int  expect_done_cyc = -1;
  int  start_cyc       = 0;
  int  first_valid_cyc = -1;
  int  done_cyc        = -1;
  int  issue_cnt       = 0;
  int  stall_issue_cnt = -1;
  bit  m_active        = 1'b0;
  bit  prev_stall      = 1'b0;
  logic [31:0] prev_data;

  logic        start_nxt  = 1'b0;
  logic        abort_nxt  = 1'b0;
  logic [9:0]  base_nxt   = '0;
  logic [9:0]  stride_nxt = 10'd1;
  logic [10:0] count_nxt  = '0;
  int ready_pct = 100;
  int low_from  = 1;
  int low_to    = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // One clock: drive this cycle's inputs just after the edge, then check outputs mid-cycle.
  task automatic next_cycle();
    bit was_active;
    @(posedge clk);
    cyc++;
    #1;
    start      = start_nxt;
    abort      = abort_nxt;
    base_addr  = base_nxt;
    count      = count_nxt;
    stride_drv = stride_nxt;
    start_nxt  = 1'b0;
    abort_nxt  = 1'b0;
    if (cyc >= low_from && cyc <= low_to) out_ready = 1'b0;
    else out_ready = ($urandom_range(0, 99) < ready_pct);
    @(negedge clk);
    was_active = m_active;

    checkOutput("done", 64'(done), 64'(cyc == expect_done_cyc));
    if (done) done_cyc = cyc;
    if (!(m_active && cyc == expect_done_cyc)) checkOutput("busy", 64'(busy), 64'(m_active));

    if (mem_enable) begin
      issue_cnt++;
      if (exp_addr_q.size() == 0) checkOutput("extra_issue", 64'd1, 64'd0);
      else checkOutput("mem_address", 64'(mem_address), 64'(exp_addr_q.pop_front()));
      outstanding++;
      checkOutput("credit", 64'(outstanding <= 4), 64'd1);
      checkOutput("mem_tied", 64'({mem_write_en, mem_conf, mem_input_data != 32'd0}), 64'd0);
    end
    if (cyc == low_to) stall_issue_cnt = issue_cnt;

    if (m_active && out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (prev_stall) begin
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_data", 64'(out_data), 64'(prev_data));
    end
    prev_stall = out_valid && !out_ready && !abort;
    prev_data  = out_data;

    if (out_valid && out_ready) begin
      if (exp_data_q.size() == 0) checkOutput("extra_word", 64'd1, 64'd0);
      else begin
        checkOutput("out_data", 64'(out_data), 64'(exp_data_q.pop_front()));
        outstanding--;
        if (exp_data_q.size() == 0 && m_active) expect_done_cyc = cyc + 1;
      end
    end

    if (m_active && cyc == expect_done_cyc) m_active = 1'b0;

    if (abort) begin
      exp_addr_q.delete();
      exp_data_q.delete();
      outstanding     = 0;
      m_active        = 1'b0;
      expect_done_cyc = -1;
      prev_stall      = 1'b0;
    end else if (start && !was_active) begin
      if (count == 11'd0) expect_done_cyc = cyc + 1;
      else begin
        m_active        = 1'b1;
        start_cyc       = cyc;
        first_valid_cyc = -1;
        issue_cnt       = 0;
        for (int i = 0; i < int'(count); i++) begin
          int a;
          a = (int'(base_addr) + i * int'(STRIDE_EN_TB ? stride_drv : 10'd1)) % 1024;
          exp_addr_q.push_back(10'(a));
          exp_data_q.push_back(mem_model[a]);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [9:0] base, input logic [9:0] strd, input logic [10:0] cnt,
                               input int pct, input int abort_after, input bit noise);
    int limit;
    ready_pct  = pct;
    base_nxt   = base;
    stride_nxt = STRIDE_EN_TB ? strd : 10'd1;
    count_nxt  = cnt;
    start_nxt  = 1'b1;
    done_cyc   = -1;
    next_cycle();
    limit = 6 * int'(cnt) + 60;
    for (int k = 0; k < limit && (m_active || cyc < expect_done_cyc); k++) begin
      if (abort_after > 0 && cyc + 1 == start_cyc + abort_after) abort_nxt = 1'b1;
      if (noise && m_active && $urandom_range(0, 7) == 0) begin
        start_nxt  = 1'b1;
        base_nxt   = 10'($urandom);
        count_nxt  = 11'($urandom_range(1, 20));
        stride_nxt = 10'($urandom);
      end
      next_cycle();
    end
    checkOutput("timeout", 64'(m_active || cyc < expect_done_cyc), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #1;
    checkOutput("reset_ctrl", 64'({busy, done, mem_enable, mem_write_en, mem_conf, out_valid}), 64'd0);
    checkOutput("reset_addr", 64'(mem_address), 64'd0);
    checkOutput("reset_data", 64'({out_data, mem_input_data}), 64'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    outstanding     = 0;
    m_active        = 1'b0;
    expect_done_cyc = -1;
    prev_stall      = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int t0;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    base_addr  = '0;
    count      = '0;
    stride_drv = 10'd1;
    out_ready  = 1'b0;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'(i);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", 64'({busy, done, mem_enable, mem_write_en, mem_conf, out_valid}), 64'd0);
    checkOutput("reset_data", 64'({out_data, mem_input_data}), 64'd0);
    checkOutput("reset_addr", 64'(mem_address), 64'd0);
    reset = 1'b0;
    repeat (2) next_cycle();

    // Sequential burst with data = address.
    applyStimulus(10'h010, 10'd1, 11'd8, 100, 0, 1'b0);
    t0 = start_cyc;
    checkOutput("first_valid_cycle", 64'(first_valid_cyc), 64'(t0 + 4));
    checkOutput("done_cycle_8", 64'(done_cyc), 64'(t0 + 12));

    // Wrap across the top of memory.
    applyStimulus(10'h3FE, 10'd1, 11'd4, 100, 0, 1'b0);
    checkOutput("done_cycle_wrap", 64'(done_cyc), 64'(start_cyc + 8));

    // Backpressure: ready low for 10 cycles starting T+4.
    low_from = cyc + 1 + 4;
    low_to   = cyc + 1 + 13;
    applyStimulus(10'h080, 10'd1, 11'd16, 100, 0, 1'b0);
    checkOutput("stall_issue_count", 64'(stall_issue_cnt), 64'd4);
    low_from = 1;
    low_to   = 0;

    // Zero-length request.
    applyStimulus(10'h055, 10'd1, 11'd0, 100, 0, 1'b0);
    t0 = cyc - 1;
    checkOutput("zero_done_cycle", 64'(done_cyc), 64'(t0 + 1));
    next_cycle();

    // Abort at T+3, then a fresh start at T+6.
    applyStimulus(10'h040, 10'd1, 11'd8, 100, 3, 1'b0);
    next_cycle();
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_valid", 64'(out_valid), 64'd0);
    next_cycle();
    applyStimulus(10'h123, 10'd1, 11'd8, 100, 0, 1'b0);
    checkOutput("restart_done_cycle", 64'(done_cyc), 64'(start_cyc + 12));

    if (STRIDE_EN_TB) begin
      applyStimulus(10'd5, 10'h100, 11'd5, 100, 0, 1'b0);
      applyStimulus(10'h2A0, 10'd0, 11'd1024, 100, 0, 1'b0);
      checkOutput("stride0_done_cycle", 64'(done_cyc), 64'(start_cyc + 1028));
    end

    // Full wrap back to base.
    applyStimulus(10'h200, 10'd1, 11'd1024, 100, 0, 1'b0);
    checkOutput("full_done_cycle", 64'(done_cyc), 64'(start_cyc + 1028));

    // Reset in the middle of a transfer.
    base_nxt  = 10'h300;
    count_nxt = 11'd20;
    start_nxt = 1'b1;
    repeat (7) next_cycle();
    do_reset();
    repeat (4) next_cycle();

    // Randomized transfers with random backpressure, aborts and ignored starts.
    for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
    for (int n = 0; n < 16; n++) begin
      logic [10:0] cnt;
      int ab;
      cnt = 11'($urandom_range(1, 40));
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(cnt)) : 0;
      applyStimulus(10'($urandom), 10'($urandom), cnt, $urandom_range(25, 100), ab, 1'b1);
      if ($urandom_range(0, 1) == 1) next_cycle();
    end
    repeat (3) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
